// File: rtl/mult_share_ctrl.sv
// Round-robin front end that shares one pipelined multiplier among NREQ requesters.
// Operand pairs are accepted one per cycle. A tag pipeline matched to the multiplier
// latency steers each product back to the requester that issued it.
module mult_share_ctrl #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         res_valid,
  output logic [2*WIDTH-1:0]      res_y,
  output logic [WIDTH-1:0]        m_a,
  output logic [WIDTH-1:0]        m_b,
  input  logic [2*WIDTH-1:0]      m_y,
  output logic [NREQ-1:0]         busy,
  output logic [31:0]             issue_cnt
);

  localparam int unsigned TW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Stage 0 is loaded with the operands; stage LAT lines up with m_y.
  localparam int unsigned NST = LAT + 1;

  logic [TW-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]      busy_q, busy_d;
  logic [NST-1:0]       pv_q;
  logic [TW-1:0]        ptag_q [NST];
  logic [WIDTH-1:0]     ma_q, mb_q;
  logic [2*WIDTH-1:0]   res_y_q;
  logic [NREQ-1:0]      res_valid_q;
  logic [31:0]          issue_cnt_q, issue_cnt_d;

  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      grant;
  logic                 grant_any;
  logic [TW-1:0]        grant_idx;
  logic [NREQ-1:0]      ret_vec;

  // A busy requester is never eligible, so ready cannot depend on its own ready.
  assign eligible = req_valid & ~busy_q;

  // Round-robin search over eligible requesters, starting at ptr and wrapping.
  always_comb begin
    int unsigned idx_int;
    logic [TW-1:0] idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx_int   = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_int = (32'(ptr_q) + k) % NREQ;
      idx     = TW'(idx_int);
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Result return decode and next-state for pointer, busy flags and counter.
  always_comb begin
    ret_vec = '0;
    if (pv_q[LAT]) ret_vec[ptag_q[LAT]] = 1'b1;
    busy_d      = (busy_q & ~ret_vec) | grant;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (grant_any) begin
      ptr_d       = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  // State registers; reset drops every in-flight tag so stale m_y is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      pv_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      res_y_q     <= '0;
      res_valid_q <= '0;
      issue_cnt_q <= '0;
      for (int unsigned k = 0; k < NST; k++) ptag_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      issue_cnt_q <= issue_cnt_d;
      if (grant_any) begin
        ma_q <= req_a[grant_idx*WIDTH +: WIDTH];
        mb_q <= req_b[grant_idx*WIDTH +: WIDTH];
      end
      pv_q[0]   <= grant_any;
      ptag_q[0] <= grant_idx;
      for (int unsigned k = 1; k < NST; k++) begin
        pv_q[k]   <= pv_q[k-1];
        ptag_q[k] <= ptag_q[k-1];
      end
      if (pv_q[LAT]) res_y_q <= m_y;
      res_valid_q <= ret_vec;
    end
  end

  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign m_a       = ma_q;
  assign m_b       = mb_q;
  assign busy      = busy_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed vectors, expected results queued at each handshake
// and checked by a separate monitor when res_valid pulses.
`timescale 1ns/1ps
module tb_mult_share_ctrl;

  localparam int unsigned WIDTH = 96;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned LAT   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       res_valid;
  logic [2*WIDTH-1:0]    res_y;
  logic [WIDTH-1:0]      m_a;
  logic [WIDTH-1:0]      m_b;
  logic [2*WIDTH-1:0]    m_y;
  logic [NREQ-1:0]       busy;
  logic [31:0]           issue_cnt;

  mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_y     (res_y),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_y       (m_y),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  // Two-stage multiplier model, no reset, like the real array multiplier.
  logic [191:0] p1, p2;
  always @(posedge clk) begin
    p1 <= {96'b0, m_a} * {96'b0, m_b};
    p2 <= p1;
  end
  assign m_y = p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  tag;
    logic [191:0] prod;
    int unsigned  cyc;
  } exp_t;

  exp_t         sb[$];
  logic [191:0] exp_prod [NREQ];
  int           n_total = 0;
  int           n_pass  = 0;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic set_op(input int i, input logic [95:0] a, input logic [95:0] b,
                        input logic [191:0] prod);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    exp_prod[i] = prod;
  endtask

  // Ends at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: results are checked first, then this cycle's handshakes are queued.
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] oh;
    #2;
    if (res_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected res_valid", res_valid, '0);
      end else begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.tag;
        chk("res_valid onehot", res_valid, oh);
        chk("res_y", res_y, e.prod);
        chk("result cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      oh = 4'b0001 << e.tag;
      chk("missing res_valid", res_valid, oh);
    end
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{tag: i, prod: exp_prod[i], cyc: cyc + LAT + 2});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0]  ones;
    logic [191:0] big;
    ones = '1;
    big  = {96'hFFFFFFFFFFFFFFFFFFFFFFFE, 96'h1};
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) exp_prod[i] = '0;

    // Reset state
    do_reset();
    #1;
    chk("reset req_ready", req_ready, '0);
    chk("reset res_valid", res_valid, '0);
    chk("reset res_y", res_y, '0);
    chk("reset m_a", m_a, '0);
    chk("reset m_b", m_b, '0);
    chk("reset busy", busy, '0);
    chk("reset issue_cnt", issue_cnt, '0);

    // Single request from requester 2: 3*5
    @(negedge clk);
    set_op(2, 96'd3, 96'd5, 192'd15);
    req_valid = 4'b0100;
    #1 chk("single ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single busy c1", busy, 4'b0100);
    chk("single m_a", m_a, 96'd3);
    chk("single m_b", m_b, 96'd5);
    @(negedge clk); #1 chk("single busy c2", busy, 4'b0100);
    @(negedge clk); #1 chk("single busy c3", busy, 4'b0100);
    @(negedge clk); #1 chk("single busy c4", busy, 4'b0000);
    repeat (3) @(negedge clk);

    // Fairness: all four valid from reset
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_op(i, 96'(i + 1), 96'd10, 192'((i + 1) * 10));
    req_valid = 4'b1111;
    #1 chk("fair grant 0", req_ready, 4'b0001);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      #1 chk($sformatf("fair grant %0d", k), req_ready, 4'b0001 << (k % 4));
    end
    @(negedge clk);
    req_valid = '0;
    #1 chk("fair issue_cnt", issue_cnt, 32'd8);
    repeat (6) @(negedge clk);

    // Back-to-back with extreme operands
    do_reset();
    @(negedge clk);
    set_op(0, ones, ones, big);
    set_op(1, 96'd7, 96'd0, 192'd0);
    req_valid = 4'b0011;
    #1 chk("b2b grant 0", req_ready, 4'b0001);
    @(negedge clk);
    #1 chk("b2b grant 1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);

    // Busy lockout on requester 3
    do_reset();
    @(negedge clk);
    set_op(3, 96'd6, 96'd7, 192'd42);
    req_valid = 4'b1000;
    #1 chk("lock grant c0", req_ready, 4'b1000);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("lock ready c%0d", k), req_ready, 4'b0000);
    end
    @(negedge clk);
    #1 chk("lock regrant c4", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);

    // Reset while requester 1 is in flight
    do_reset();
    @(negedge clk);
    set_op(1, 96'd11, 96'd13, 192'd143);
    set_op(3, 96'd2, 96'd2, 192'd4);
    req_valid = 4'b0010;
    #1 chk("midrst grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst busy", busy, '0);
    chk("midrst issue_cnt", issue_cnt, '0);
    chk("midrst m_a", m_a, '0);
    req_valid = 4'b1010;
    #1 chk("midrst lowest grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (7) @(negedge clk);

    // Counter wrap
    @(negedge clk);
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_q;
    set_op(0, 96'd9, 96'd9, 192'd81);
    req_valid = 4'b0001;
    #1 chk("wrap grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1 chk("wrap issue_cnt", issue_cnt, 32'd0);
    repeat (6) @(negedge clk);

    chk("scoreboard drained", 192'(sb.size()), 192'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
